seg_scan4: RTL and testbench
============================

# seg_scan4

Four-digit multiplexed seven-segment display driver. It takes up to four BCD digits from the counter stages (seconds and minutes counts) and time-multiplexes them onto a single shared segment bus with one-hot digit enables. It inserts a blanking gap between digits to prevent ghosting, updates the displayed value only at frame boundaries so a frame never tears, and optionally blanks leading zeros. It sits directly downstream of the counter chain and replaces a single-digit combinational decoder at the board pins.

## Interface
- `DWELL_CYC`, default 24000: clock cycles each digit is lit (1 ms at 24 MHz). Must be ≥1.
- `GAP_CYC`, default 240: clock cycles of all-off blanking between digits. Must be ≥1.
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `bcd_in`, input, 16: four BCD digits. [3:0] is digit 0 (rightmost); [15:12] is digit 3 (leftmost).
- `load`, input, 1: capture strobe, one cycle. `bcd_in` is sampled on any edge where `load`=1.
- `blank_lz`, input, 1: leading-zero blanking enable. Level-sensitive; sampled at frame capture.
- `a_g`, output, 7: segments, active-high. a_g[6]=a … a_g[0]=g. Registered.
- `dig_sel`, output, 4: digit enables, one-hot, active-high. dig_sel[0] is digit 0. Registered.
- `frame_done`, output, 1: one-cycle pulse when the digit-3 lit phase ends. Registered.

## Operation
- **Registers**
  - `shadow[15:0]`: written from `bcd_in` whenever `load`=1.
  - `disp[15:0]` and `lz_en`: the frame copy.
  - `idx[1:0]`: digit index.
  - `cnt`: phase counter, width ceil(log2(max(DWELL_CYC, GAP_CYC)+1)).
  - `state` ∈ {GAP, ON}.
- **State machine**
  - GAP: `dig_sel`=0, `a_g`=0. `cnt` counts 0..GAP_CYC-1. At GAP_CYC-1: go to ON, cnt=0.
  - ON: `dig_sel`=1<<idx, `a_g`=decode(disp digit idx). `cnt` counts 0..DWELL_CYC-1. At DWELL_CYC-1: go to GAP, cnt=0, idx=idx+1 (wraps 3→0).
- **Frame capture** (on the GAP→ON edge with idx=0):
  - disp ← (load ? bcd_in : shadow).
  - lz_en ← blank_lz.
  - A `load` on that same edge bypasses `shadow` and is displayed in this frame. `shadow` is also updated as normal.
  - `load` at any other time is held in `shadow` until the next frame start. Mid-frame digits never change.
- **Decode** (abcdefg hex):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B.
  - Codes 10–15 display "-" (01).
- **Leading-zero blanking** (when lz_en=1):
  - Digit k (k=3,2,1) is blanked (`a_g`=0, `dig_sel` still asserted) if it and all higher digits equal 0.
  - Digit 0 is never blanked. Codes 10–15 count as nonzero.
- **frame_done**: high for exactly the one cycle following the last digit-3 ON cycle, i.e. the first GAP cycle after digit 3.
- **Reset** (any cycle, including mid-dwell):
  - `a_g`=0, `dig_sel`=0, `frame_done`=0.
  - state=GAP, idx=0, cnt=0, shadow=0, disp=0, lz_en=0.
  - `load` is ignored while `rst`=1.

## Timing
- Outputs change only on clock edges, with no combinational path from inputs to outputs.
- Let edge E be the first edge with `rst`=0. Cycles E..E+GAP_CYC-1 are in GAP. `dig_sel`=0001 is visible from edge E+GAP_CYC for DWELL_CYC cycles.
- Digit period is DWELL_CYC+GAP_CYC. Frame period is 4·(DWELL_CYC+GAP_CYC). `dig_sel` is never multi-hot and is never lit in adjacent cycles across digits.
- Load-to-display latency is frame-bounded:
  - Best case: `load` on the capture edge is visible that same edge.
  - Worst case: just under one frame period.
- With `load` held high continuously, each frame shows the `bcd_in` value present on its capture edge.

## Test plan
All scenarios use DWELL_CYC=3 and GAP_CYC=2.
- **Reset/sequence**: release `rst`.
  - Expect `dig_sel`=0 for 2 cycles, then 0001×3, 0000×2, 0010×3, 0000×2, 0100×3, 0000×2, 1000×3.
  - Expect `frame_done`=1 on the next cycle only, then 0001 again after 2 gap cycles.
- **Decode**: `load` with bcd_in=16'h1234, blank_lz=0.
  - Next frame: digit0 `a_g`=33, digit1=79, digit2=6D, digit3=30.
  - Repeat with 16'h5678 (5F/70/7F and 5B on digit3 per position). Then 16'h90AF gives digit0=01, digit1=01, digit2=7E, digit3=7B.
- **Leading-zero blanking**: blank_lz=1.
  - bcd_in=16'h0040: digits 3,2 show `a_g`=00, digit1=33, digit0=7E.
  - bcd_in=16'h0000: only digit0 is lit (7E).
  - bcd_in=16'h00A0: digit1=01, digit2/3 blank.
- **Tear-free update**: load 16'h1111, then during digit1 ON load 16'h2222. The remainder of the frame shows 30. The next frame shows 6D on all digits.
- **Simultaneous capture**: assert `load` with 16'h9999 exactly on the GAP→ON edge of digit0. That frame's digit0 shows 7B immediately.
- **Mid-operation reset**: assert `rst` for 1 cycle during digit2 ON.
  - Next cycle: `a_g`=0, `dig_sel`=0.
  - After release: 2 gap cycles, then digit0 lit with `a_g`=7E (disp cleared to 0).

Source files
------------

// File: rtl/seg_scan4.sv
// seg_scan4: four-digit multiplexed seven-segment display driver.
// Scans four BCD digits onto a shared segment bus with one-hot digit
// enables. A blanking gap separates digits to prevent ghosting. The
// displayed value is latched only at frame start, so a frame never shows
// a mix of old and new digits. Leading zeros can optionally be blanked.
//
// Output timing: every output is a register loaded from the current scan
// state. Outputs therefore trail the internal state by one clock. As a
// result, the first lit digit after reset appears GAP_CYC edges after the
// first edge with rst low.
module seg_scan4 #(
  parameter int DWELL_CYC = 24000,
  parameter int GAP_CYC   = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [6:0]  a_g,
  output logic [3:0]  dig_sel,
  output logic        frame_done
);

  // Phase counter must hold the larger of the two terminal counts.
  localparam int MAX_CYC = (DWELL_CYC > GAP_CYC) ? DWELL_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);

  typedef enum logic {
    ST_GAP = 1'b0,
    ST_ON  = 1'b1
  } state_t;

  // Segment pattern for one BCD code, abcdefg with a in bit 6.
  // Codes 10..15 are not valid BCD and show a dash instead.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'h7E;
      4'd1:    seg = 7'h30;
      4'd2:    seg = 7'h6D;
      4'd3:    seg = 7'h79;
      4'd4:    seg = 7'h33;
      4'd5:    seg = 7'h5B;
      4'd6:    seg = 7'h5F;
      4'd7:    seg = 7'h70;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h7B;
      default: seg = 7'h01;
    endcase
    return seg;
  endfunction

  // Scan state
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       idx, idx_nxt;
  logic             capture;     // frame start: GAP->ON with idx 0
  logic             last_on;     // final cycle of digit 3 lit phase

  // Value storage
  logic [15:0]      shadow;
  logic [15:0]      disp;
  logic             lz_en;

  // Per-digit view of the frame copy
  logic [3:0]       cur_code;
  logic [3:0]       dig_zero;
  logic             cur_blank;

  // Pipeline stage for the frame-done pulse
  logic             fd_pend;

  // Scan state register.
  // NOTE: sequential state uses non-blocking assignments. Every register
  // then updates from values sampled before the edge, whatever the
  // block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_GAP;
      cnt   <= '0;
      idx   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state logic. GAP and ON phases alternate; idx advances after
  // each lit phase.
  // NOTE: every output of this block gets a default first. This way no
  // path through the case leaves a variable unassigned, which would
  // otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    capture   = 1'b0;
    last_on   = 1'b0;
    case (state)
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = ST_ON;
          cnt_nxt   = '0;
          capture   = (idx == 2'd0);
        end
      end
      ST_ON: begin
        if (cnt == DWELL_LAST) begin
          state_nxt = ST_GAP;
          cnt_nxt   = '0;
          idx_nxt   = idx + 2'd1;
          last_on   = (idx == 2'd3);
        end
      end
      default: begin
        state_nxt = ST_GAP;
        cnt_nxt   = '0;
        idx_nxt   = 2'd0;
      end
    endcase
  end

  // Shadow holds the most recent load until the next frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= 16'h0000;
    end else if (load) begin
      shadow <= bcd_in;
    end
  end

  // Frame copy. A load on the capture edge bypasses the shadow so the
  // new value is shown in this frame rather than one frame later.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp  <= 16'h0000;
      lz_en <= 1'b0;
    end else if (capture) begin
      disp  <= load ? bcd_in : shadow;
      lz_en <= blank_lz;
    end
  end

  // Select the current digit and decide whether it is a leading zero.
  // A digit is blanked only if it and every digit to its left are zero.
  // Digit 0 is always shown so a zero value still displays "0".
  always_comb begin
    cur_code  = disp[{idx, 2'b00} +: 4];
    dig_zero  = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      dig_zero[k] = (disp[4*k +: 4] == 4'd0);
    end
    cur_blank = 1'b0;
    case (idx)
      2'd1:    cur_blank = dig_zero[3] & dig_zero[2] & dig_zero[1];
      2'd2:    cur_blank = dig_zero[3] & dig_zero[2];
      2'd3:    cur_blank = dig_zero[3];
      default: cur_blank = 1'b0;
    endcase
    cur_blank = cur_blank & lz_en;
  end

  // Registered outputs. Each is driven from the current scan state, so
  // there is no combinational path from any input to a pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_g        <= 7'h00;
      dig_sel    <= 4'b0000;
      fd_pend    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (state == ST_ON) begin
        dig_sel <= 4'b0001 << idx;
        a_g     <= cur_blank ? 7'h00 : seg_decode(cur_code);
      end else begin
        dig_sel <= 4'b0000;
        a_g     <= 7'h00;
      end
      fd_pend    <= last_on;
      frame_done <= fd_pend;
    end
  end

endmodule

// File: tb/tb_seg_scan4.sv
// tb_seg_scan4: self-checking bench for seg_scan4 with DWELL_CYC=3, GAP_CYC=2.
// A time-based model predicts the outputs from the number of edges since
// reset. It is compared on every falling edge. Directed scenarios add
// literal expectations that pin both the DUT and the model.
module tb_seg_scan4;

  localparam int DW    = 3;
  localparam int GP    = 2;
  localparam int DIG   = DW + GP;
  localparam int FRAME = 4 * DIG;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd_in;
  logic        load;
  logic        blank_lz;
  logic [6:0]  a_g;
  logic [3:0]  dig_sel;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  seg_scan4 #(.DWELL_CYC(DW), .GAP_CYC(GP)) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .a_g        (a_g),
    .dig_sel    (dig_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0]  seg_tab [0:15] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                  7'h7F, 7'h7B, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01};
  bit          m_valid = 1'b0;
  int          m_t;
  logic [15:0] m_shadow, m_frame;
  logic        m_lz;
  logic [3:0]  exp_sel;
  logic [6:0]  exp_seg;
  logic        exp_fd;

  // Edge t after reset release: position p in the frame. The digit is
  // p/DIG. The first GP positions of each digit slot are dark. The frame
  // value is latched on the last dark edge before digit 0 lights.
  always @(posedge clk) begin
    int p, d, ph;
    logic [15:0] upper;
    if (rst) begin
      m_valid  = 1'b1;
      m_t      = -1;
      m_shadow = '0;
      m_frame  = '0;
      m_lz     = 1'b0;
      exp_sel  = '0;
      exp_seg  = '0;
      exp_fd   = 1'b0;
    end else if (m_valid) begin
      m_t++;
      p  = m_t % FRAME;
      if (p == GP - 1) begin
        m_frame = load ? bcd_in : m_shadow;
        m_lz    = blank_lz;
      end
      if (load) m_shadow = bcd_in;
      d  = p / DIG;
      ph = p % DIG;
      exp_fd = (p == 0) && (m_t > 0);
      if (ph >= GP) begin
        exp_sel = 4'(1 << d);
        upper   = m_frame >> (4 * d);
        exp_seg = (m_lz && d > 0 && upper == 16'h0) ? 7'h00 : seg_tab[upper[3:0]];
      end else begin
        exp_sel = '0;
        exp_seg = '0;
      end
    end
  end

  // Compare every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_dig_sel", dig_sel, exp_sel);
      check("model_a_g", a_g, exp_seg);
      check("model_frame_done", frame_done, exp_fd);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic expect_digit(input logic [3:0] sel, input logic [6:0] seg, input string name);
    int n = 0;
    while (dig_sel !== sel && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check({name, "_sel"}, dig_sel, sel);
    check(name, a_g, seg);
  endtask

  task automatic wait_fd();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 2 * FRAME);
    check("frame_done_seen", frame_done, 1'b1);
  endtask

  task automatic pulse_load(input logic [15:0] v);
    bcd_in = v;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  logic [3:0] seq_sel [0:22] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2,
                                 4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h8, 4'h8, 4'h8,
                                 4'h0, 4'h0, 4'h1};

  initial begin
    rst = 1'b1; load = 1'b0; blank_lz = 1'b0; bcd_in = 16'h0;
    repeat (3) @(negedge clk);
    check("reset_dig_sel", dig_sel, 4'h0);
    check("reset_a_g", a_g, 7'h00);
    check("reset_frame_done", frame_done, 1'b0);

    // Reset release and scan sequence
    rst = 1'b0;
    for (int i = 0; i <= 22; i++) begin
      @(negedge clk);
      check($sformatf("seq_sel_%0d", i), dig_sel, seq_sel[i]);
      check($sformatf("seq_fd_%0d", i), frame_done, (i == 20) ? 1'b1 : 1'b0);
      if (i == 2) check("seq_d0_zero", a_g, 7'h7E);
    end

    // Decode
    pulse_load(16'h1234);
    wait_fd();
    expect_digit(4'h1, 7'h33, "dec1234_d0");
    expect_digit(4'h2, 7'h79, "dec1234_d1");
    expect_digit(4'h4, 7'h6D, "dec1234_d2");
    expect_digit(4'h8, 7'h30, "dec1234_d3");
    pulse_load(16'h5678);
    wait_fd();
    expect_digit(4'h1, 7'h7F, "dec5678_d0");
    expect_digit(4'h2, 7'h70, "dec5678_d1");
    expect_digit(4'h4, 7'h5F, "dec5678_d2");
    expect_digit(4'h8, 7'h5B, "dec5678_d3");
    pulse_load(16'h90AF);
    wait_fd();
    expect_digit(4'h1, 7'h01, "dec90af_d0");
    expect_digit(4'h2, 7'h01, "dec90af_d1");
    expect_digit(4'h4, 7'h7E, "dec90af_d2");
    expect_digit(4'h8, 7'h7B, "dec90af_d3");

    // Leading-zero blanking
    blank_lz = 1'b1;
    pulse_load(16'h0040);
    wait_fd();
    expect_digit(4'h1, 7'h7E, "lz0040_d0");
    expect_digit(4'h2, 7'h33, "lz0040_d1");
    expect_digit(4'h4, 7'h00, "lz0040_d2");
    expect_digit(4'h8, 7'h00, "lz0040_d3");
    pulse_load(16'h0000);
    wait_fd();
    expect_digit(4'h1, 7'h7E, "lz0000_d0");
    expect_digit(4'h2, 7'h00, "lz0000_d1");
    expect_digit(4'h4, 7'h00, "lz0000_d2");
    expect_digit(4'h8, 7'h00, "lz0000_d3");
    pulse_load(16'h00A0);
    wait_fd();
    expect_digit(4'h1, 7'h7E, "lz00a0_d0");
    expect_digit(4'h2, 7'h01, "lz00a0_d1");
    expect_digit(4'h4, 7'h00, "lz00a0_d2");
    expect_digit(4'h8, 7'h00, "lz00a0_d3");
    blank_lz = 1'b0;

    // Tear-free update
    pulse_load(16'h1111);
    wait_fd();
    expect_digit(4'h1, 7'h30, "tear_d0");
    expect_digit(4'h2, 7'h30, "tear_d1_pre");
    pulse_load(16'h2222);
    expect_digit(4'h2, 7'h30, "tear_d1_post");
    expect_digit(4'h4, 7'h30, "tear_d2");
    expect_digit(4'h8, 7'h30, "tear_d3");
    wait_fd();
    expect_digit(4'h1, 7'h6D, "next_d0");
    expect_digit(4'h2, 7'h6D, "next_d1");
    expect_digit(4'h4, 7'h6D, "next_d2");
    expect_digit(4'h8, 7'h6D, "next_d3");

    // Simultaneous capture: frame_done marks the cycle whose closing edge
    // is the frame capture edge.
    wait_fd();
    pulse_load(16'h9999);
    expect_digit(4'h1, 7'h7B, "simul_d0");
    expect_digit(4'h2, 7'h7B, "simul_d1");

    // Mid-operation reset during digit 2; a load during reset is ignored.
    expect_digit(4'h4, 7'h7B, "prerst_d2");
    rst = 1'b1; load = 1'b1; bcd_in = 16'h8888;
    @(negedge clk);
    check("midrst_a_g", a_g, 7'h00);
    check("midrst_dig_sel", dig_sel, 4'h0);
    rst = 1'b0; load = 1'b0;
    @(negedge clk);
    check("postrst_gap0", dig_sel, 4'h0);
    @(negedge clk);
    check("postrst_gap1", dig_sel, 4'h0);
    @(negedge clk);
    check("postrst_d0_sel", dig_sel, 4'h1);
    check("postrst_d0_seg", a_g, 7'h7E);
    repeat (FRAME) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
